apb_master_ctrl: RTL and testbench

Synthesizable APB4 requester that replaces task-driven stimulus with an RTL engine.
- Accepts read/write commands on a valid/ready port and buffers them in a small command FIFO.
- Drives the APB SETUP/ACCESS protocol with PREADY wait states, PSTRB byte strobes and PSLVERR capture.
- Returns one response per command.
- Sits between a test sequencer or on-chip master and any APB completer.

---
 rtl/apb_master_ctrl_pkg.sv | 22 ++
 rtl/apb_cmd_fifo.sv | 60 ++++++
 rtl/apb_master_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_ctrl_pkg.sv
// Shared types for the APB4 requester: FSM state encoding and the buffered command record.
// The address/data widths below are the default widths of apb_master_ctrl.
package apb_master_ctrl_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [APB_STRB_WIDTH-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with a first-word-fall-through read port.
// Pointers wrap at DEPTH (a power of two); count spans 0..DEPTH.
module apb_cmd_fifo
  import apb_master_ctrl_pkg::*;
#(
  parameter type entry_t = apb_cmd_t,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  entry_t           mem_q [DEPTH];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every variable gets a value before any branch, so no latch can be inferred.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it was written, so the reset pointers suffice.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 requester: buffers valid/ready commands and runs IDLE/SETUP/ACCESS with one response per command.
// Optional build macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait states.
module apb_master_ctrl #(
  parameter int APB_ADDR_WIDTH = apb_master_ctrl_pkg::APB_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = apb_master_ctrl_pkg::APB_DATA_WIDTH,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        apbClk,
  input  logic                        rst,
  input  logic                        cmdValid,
  output logic                        cmdReady,
  input  logic                        cmdWrite,
  input  logic [APB_ADDR_WIDTH-1:0]   cmdAddr,
  input  logic [APB_DATA_WIDTH-1:0]   cmdWdata,
  input  logic [APB_DATA_WIDTH/8-1:0] cmdStrb,
  output logic                        rspValid,
  output logic [APB_DATA_WIDTH-1:0]   rspRdata,
  output logic                        rspErr,
  output logic                        PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]   PADDR,
  output logic [APB_DATA_WIDTH-1:0]   PWDATA,
  output logic [APB_DATA_WIDTH/8-1:0] PSTRB,
  input  logic [APB_DATA_WIDTH-1:0]   PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR
);

  import apb_master_ctrl_pkg::*;

  localparam int STRB_W = APB_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(CMD_DEPTH + 1);

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]         strb;
  } cmd_t;

  apb_state_e                state_q, state_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]         pstrb_q, pstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      cmd_ready_q, cmd_ready_d;

  logic             push, pop, fifo_full, fifo_empty, xfer_done;
  logic [CNT_W-1:0] fifo_count, count_nxt;
  cmd_t             fifo_wdata, fifo_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign fifo_wdata = '{write: cmdWrite, addr: cmdAddr, wdata: cmdWdata, strb: cmdStrb};

  apb_cmd_fifo #(
    .entry_t (cmd_t),
    .DEPTH   (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (apbClk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    xfer_done   = psel_q && penable_q && PREADY;
`ifdef APB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      ACCESS: begin
        if (xfer_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
          penable_d   = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            psel_d   = 1'b0;
            pwrite_d = 1'b0;
            pstrb_d  = '0;
            state_d  = IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + 1'b1;
          // A stuck completer: abort with an error response; any queued work restarts from IDLE.
          if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            pwrite_d    = 1'b0;
            pstrb_d     = '0;
            state_d     = IDLE;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Any pop launches the popped command into SETUP; reads never drive byte strobes.
    if (pop) begin
      pwrite_d = fifo_rdata.write;
      paddr_d  = fifo_rdata.addr;
      pwdata_d = fifo_rdata.wdata;
      pstrb_d  = fifo_rdata.write ? fifo_rdata.strb : '0;
    end

    push        = cmdValid && cmd_ready_q && !fifo_full;
    count_nxt   = fifo_count + CNT_W'(push) - CNT_W'(pop);
    cmd_ready_d = (count_nxt != CNT_W'(CMD_DEPTH));
  end

  always_ff @(posedge apbClk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign cmdReady = cmd_ready_q;
  assign rspValid = rsp_valid_q;
  assign rspRdata = rsp_rdata_q;
  assign rspErr   = rsp_err_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PSTRB    = pstrb_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: scripted APB completer, response scoreboard,
// a vector table of single transfers and hand-written multi-cycle sequences.
module tb_apb_master_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          apbClk = 1'b0;
  logic          rst;
  logic          cmdValid, cmdReady, cmdWrite;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdWdata;
  logic [SW-1:0] cmdStrb;
  logic          rspValid, rspErr;
  logic [DW-1:0] rspRdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA  = '0;
  logic          PREADY  = 1'b0;
  logic          PSLVERR = 1'b0;

  always #5 apbClk = ~apbClk;

  apb_master_ctrl #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .apbClk   (apbClk),
    .rst      (rst),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdWrite (cmdWrite),
    .cmdAddr  (cmdAddr),
    .cmdWdata (cmdWdata),
    .cmdStrb  (cmdStrb),
    .rspValid (rspValid),
    .rspRdata (rspRdata),
    .rspErr   (rspErr),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Command plus the completer's scripted reaction to it.
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [15:0]   waits;
    logic          slverr;
    logic [DW-1:0] prdata;
  } beh_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  typedef struct {
    beh_t          cmd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  exp_t exp_q[$];
  beh_t beh_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rsp_seen = 0;
  int   acc_cnt  = 0;
  logic done_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beh_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, input int wt, input logic e,
                              input logic [DW-1:0] r);
    beh_t b;
    b.write  = w;
    b.addr   = a;
    b.wdata  = d;
    b.strb   = s;
    b.waits  = 16'(wt);
    b.slverr = e;
    b.prdata = r;
    return b;
  endfunction

  function automatic exp_t ex(input logic [DW-1:0] r, input logic e);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    return x;
  endfunction

  // Completer model plus per-cycle check of the APB request against the head command.
  always @(negedge apbClk) begin
    beh_t b;
    if (done_pending) begin
      if (beh_q.size() > 0) void'(beh_q.pop_front());
      acc_cnt      = 0;
      done_pending = 1'b0;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0BAD_F00D;
    if (!rst && PSEL) begin
      if (beh_q.size() == 0) begin
        check("psel_without_cmd", PSEL, 0);
      end else begin
        b = beh_q[0];
        check("paddr", PADDR, b.addr);
        check("pwrite", PWRITE, b.write);
        check("pstrb", PSTRB, b.write ? b.strb : 4'h0);
        if (b.write) check("pwdata", PWDATA, b.wdata);
        if (PENABLE) begin
          if (acc_cnt == int'(b.waits)) begin
            PREADY       = 1'b1;
            PSLVERR      = b.slverr;
            PRDATA       = b.prdata;
            done_pending = 1'b1;
          end else begin
            acc_cnt++;
          end
        end
      end
    end
  end

  // Response scoreboard.
  always @(negedge apbClk) begin
    exp_t e;
    if (!rst && rspValid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", rspValid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rspRdata, e.rdata);
        check("rsp_err", rspErr, e.err);
      end
    end
  end

  task automatic send(input beh_t b, input exp_t e);
    int guard = 0;
    cmdValid = 1'b1;
    cmdWrite = b.write;
    cmdAddr  = b.addr;
    cmdWdata = b.wdata;
    cmdStrb  = b.strb;
    while (!cmdReady && guard < 100) begin
      @(negedge apbClk);
      guard++;
    end
    if (!cmdReady) check("cmd_ready_timeout", cmdReady, 1);
    beh_q.push_back(b);
    exp_q.push_back(e);
    @(negedge apbClk);
    cmdValid = 1'b0;
  endtask

  task automatic wait_rsps(input int target);
    int guard = 0;
    while (rsp_seen < target && guard < 300) begin
      @(negedge apbClk);
      #1;
      guard++;
    end
    check("rsp_count", rsp_seen, target);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    beh_t b;
    int   base;
    int   acc;

    vecs[0] = '{mk(0, 32'h20, 32'h0, 4'hF, 3, 0, 32'h1234_5678), 32'h1234_5678, 1'b0};
    vecs[1] = '{mk(1, 32'h24, 32'hA5A5_A5A5, 4'h3, 1, 1, 32'hCAFE_F00D), 32'h0, 1'b1};
    vecs[2] = '{mk(0, 32'h28, 32'h0, 4'h0, 0, 0, 32'h89AB_CDEF), 32'h89AB_CDEF, 1'b0};
    vecs[3] = '{mk(0, 32'h2C, 32'h0, 4'h0, 2, 1, 32'hFFFF_0000), 32'h0, 1'b1};
    vecs[4] = '{mk(1, 32'h30, 32'h1122_3344, 4'h0, 0, 0, 32'hCAFE_F00D), 32'h0, 1'b0};
    vecs[5] = '{mk(1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 5, 0, 32'h5555_5555), 32'h0, 1'b0};
    vecs[6] = '{mk(0, 32'h0, 32'h0, 4'hF, 0, 0, 32'h0000_0001), 32'h0000_0001, 1'b0};

    rst = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0;
    cmdAddr = '0; cmdWdata = '0; cmdStrb = '0;
    repeat (3) @(negedge apbClk);
    check("rst_cmd_ready", cmdReady, 0);
    check("rst_rsp_valid", rspValid, 0);
    check("rst_rsp_rdata", rspRdata, 0);
    check("rst_rsp_err", rspErr, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pstrb", PSTRB, 0);
    rst = 1'b0;
    @(negedge apbClk);
    check("ready_after_rst", cmdReady, 1);

    // Single zero-wait write: SETUP then exactly one ACCESS cycle.
    send(mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'hCAFE_F00D), ex(32'h0, 1'b0));
    @(negedge apbClk);
    check("w1_setup_psel", PSEL, 1);
    check("w1_setup_penable", PENABLE, 0);
    check("w1_setup_pstrb", PSTRB, 4'hF);
    @(negedge apbClk);
    check("w1_access_psel", PSEL, 1);
    check("w1_access_penable", PENABLE, 1);
    @(negedge apbClk);
    check("w1_done_psel", PSEL, 0);
    check("w1_done_penable", PENABLE, 0);
    check("w1_done_rsp_valid", rspValid, 1);
    check("w1_idle_pwrite", PWRITE, 0);
    check("w1_idle_pstrb", PSTRB, 0);
    check("w1_idle_paddr_held", PADDR, 32'h10);
    wait_rsps(1);

    for (int i = 0; i < 7; i++) begin
      base = rsp_seen;
      send(vecs[i].cmd, ex(vecs[i].exp_rdata, vecs[i].exp_err));
      wait_rsps(base + 1);
    end

    // Five back-to-back commands behind a slow first transfer fill the FIFO.
    base = rsp_seen;
    send(mk(1, 32'h100, 32'h0000_0001, 4'hF, 6, 0, 32'h0), ex(32'h0, 1'b0));
    send(mk(0, 32'h104, 32'h0, 4'hF, 0, 0, 32'h0000_0104), ex(32'h0000_0104, 1'b0));
    send(mk(1, 32'h108, 32'h0000_0108, 4'h5, 1, 0, 32'h0), ex(32'h0, 1'b0));
    send(mk(0, 32'h10C, 32'h0, 4'h0, 0, 0, 32'h0000_010C), ex(32'h0000_010C, 1'b0));
    send(mk(1, 32'h110, 32'h0000_0110, 4'hA, 2, 0, 32'h0), ex(32'h0, 1'b0));
    check("b2b_full_ready", cmdReady, 0);
    for (int k = 0; k < 300 && rsp_seen < base + 5; k++) begin
      check("b2b_psel", PSEL, 1);
      @(negedge apbClk);
      #1;
    end
    wait_rsps(base + 5);

    // Reset in ACCESS with two commands queued: no responses, FIFO emptied.
    base = rsp_seen;
    send(mk(0, 32'h200, 32'h0, 4'h0, 20, 0, 32'h0), ex(32'h0, 1'b0));
    send(mk(1, 32'h204, 32'h1, 4'hF, 0, 0, 32'h0), ex(32'h0, 1'b0));
    send(mk(1, 32'h208, 32'h2, 4'hF, 0, 0, 32'h0), ex(32'h0, 1'b0));
    for (int k = 0; k < 20 && !(PSEL && PENABLE); k++) @(negedge apbClk);
    check("rst_test_in_access", PENABLE, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_psel", PSEL, 0);
    check("rst_async_penable", PENABLE, 0);
    exp_q.delete();
    beh_q.delete();
    acc_cnt = 0;
    done_pending = 1'b0;
    repeat (3) begin
      @(negedge apbClk);
      check("rst_hold_rsp_valid", rspValid, 0);
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge apbClk);
      check("post_rst_psel", PSEL, 0);
      check("post_rst_rsp_valid", rspValid, 0);
    end
    check("post_rst_ready", cmdReady, 1);
    check("post_rst_no_rsp", rsp_seen, base);

    base = rsp_seen;
    send(mk(0, 32'h40, 32'h0, 4'hF, 1, 0, 32'h5555_AAAA), ex(32'h5555_AAAA, 1'b0));
    wait_rsps(base + 1);

`ifdef APB_TIMEOUT_EN
    // PREADY in the cycle the counter would hit the limit still completes normally.
    base = rsp_seen;
    send(mk(0, 32'h300, 32'h0, 4'h0, TO - 1, 0, 32'h0F0F_0F0F), ex(32'h0F0F_0F0F, 1'b0));
    wait_rsps(base + 1);

    base = rsp_seen;
    b = mk(0, 32'h304, 32'h0, 4'h0, 1000, 0, 32'h7777_7777);
    send(b, ex(32'h0, 1'b1));
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge apbClk);
      #1;
      if (PSEL && PENABLE) acc++;
      if (acc > 0 && !PSEL) break;
    end
    check("timeout_access_cycles", acc, TO);
    check("timeout_psel_drop", PSEL, 0);
    check("timeout_penable_drop", PENABLE, 0);
    if (beh_q.size() > 0) void'(beh_q.pop_front());
    acc_cnt = 0;
    wait_rsps(base + 1);
`else
    // Without the timeout the requester waits as long as the completer stalls.
    base = rsp_seen;
    b = mk(0, 32'h300, 32'h0, 4'h0, 40, 0, 32'h0F0F_0F0F);
    send(b, ex(32'h0F0F_0F0F, 1'b0));
    wait_rsps(base + 1);
`endif

    repeat (3) @(negedge apbClk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
